apb_slave_regbank: RTL and testbench

//  APB slave register bank: the completer side of the APB master sequences driven in hw2.
//  It decodes psel/penable/pwrite/paddr/pwdata and inserts programmable wait states on pready.
//  It returns prdata and flags bad accesses on pslverr.
//  It holds a wait-config register, a read-only transfer-count status register and a set of scratch registers.

---
 rtl/apb_slave_regbank.sv | 125 ++++++++++++
 tb/tb_apb_slave_regbank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// APB completer with programmable wait states: WAIT_CFG, read-only transfer-count STATUS
// and a bank of R/W scratch registers.
module apb_slave_regbank #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SCRATCH = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [2:0]        RESET_WAIT  = 3'd0
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(8 + 4 * (NUM_SCRATCH - 1));

    state_t              state, state_nx;
    logic [2:0]          cnt, cnt_nx;
    logic [2:0]          wait_cfg;
    logic [15:0]         wr_cnt, rd_cnt;
    logic [DATA_W-1:0]   scratch [NUM_SCRATCH];
    logic [ADDR_W:0]     diff;
    logic [ADDR_W-1:0]   off;
    logic                below, hit_wait, hit_stat, err;
    logic                commit, wr_ok, rd_ok;
    logic [DATA_W-1:0]   rd_data;
    logic                pready_nx, pslverr_nx;
    logic [DATA_W-1:0]   prdata_nx;

    // Extra borrow bit flags addresses under BASE_ADDR without a constant compare.
    assign diff     = {1'b0, paddr} - {1'b0, BASE_ADDR};
    assign below    = diff[ADDR_W];
    assign off      = diff[ADDR_W-1:0];
    assign hit_wait = (off == '0);
    assign hit_stat = (off == ADDR_W'(4));
    assign err      = below | (off[1:0] != 2'b00) | (off > LAST_OFF) | (pwrite & hit_stat);

    assign commit = (state == ACCESS) & psel & penable & (cnt == 3'd0);
    assign wr_ok  = commit & pwrite & ~err;
    assign rd_ok  = commit & ~pwrite & ~err;

    always_comb begin
        rd_data = '0;
        if (hit_wait)
            rd_data = DATA_W'(wait_cfg);
        else if (hit_stat)
            rd_data = DATA_W'({rd_cnt, wr_cnt});
        else
            for (int k = 0; k < NUM_SCRATCH; k++)
                if (off[ADDR_W-1:2] == (ADDR_W-2)'(k + 2)) rd_data = scratch[k];
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (psel) begin
                state_nx = ACCESS;
                cnt_nx   = wait_cfg;
            end
            ACCESS: begin
                if (!psel)
                    state_nx = IDLE;
                else if (penable) begin
                    if (cnt != 3'd0) cnt_nx = cnt - 3'd1;
                    else             state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pready_nx  = commit;
        pslverr_nx = commit & err;
        prdata_nx  = rd_ok ? rd_data : '0;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= pready_nx;
            pslverr <= pslverr_nx;
            prdata  <= prdata_nx;
        end
    end

    // A STATUS read sees the pre-increment count since prdata and the counter share the edge.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cfg <= RESET_WAIT;
            wr_cnt   <= 16'd0;
            rd_cnt   <= 16'd0;
            for (int k = 0; k < NUM_SCRATCH; k++) scratch[k] <= '0;
        end else begin
            if (wr_ok) wr_cnt <= wr_cnt + 16'd1;
            if (rd_ok) rd_cnt <= rd_cnt + 16'd1;
            if (wr_ok && hit_wait) wait_cfg <= pwdata[2:0];
            for (int k = 0; k < NUM_SCRATCH; k++)
                if (wr_ok && off[ADDR_W-1:2] == (ADDR_W-2)'(k + 2)) scratch[k] <= pwdata;
        end
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed + random bench for apb_slave_regbank; a reference model predicts each transfer
// into a scoreboard queue that is drained when pready is observed.
module tb_apb_slave_regbank;
    logic        pclk = 1'b0;
    logic        preset, psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  m_wait;
    logic [15:0] m_wr, m_rd;
    logic [31:0] m_scr [6];
    logic [31:0] last_rd;

    apb_slave_regbank dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 3'd0; m_wr = 16'd0; m_rd = 16'd0;
        for (int k = 0; k < 6; k++) m_scr[k] = 32'd0;
    endtask

    // Reference model: expected response plus register/counter side effects.
    task automatic predict(input logic wr, input logic [15:0] a, input logic [31:0] d, output exp_t e);
        logic [31:0] v;
        e.lat  = int'(m_wait) + 1;
        e.err  = (a[1:0] != 2'b00) || (a > 16'h1C) || (wr && a == 16'h4);
        e.data = 32'd0;
        if (!e.err) begin
            if (a == 16'h0)      v = {29'd0, m_wait};
            else if (a == 16'h4) v = {m_rd, m_wr};
            else                 v = m_scr[(a - 16'h8) >> 2];
            if (wr) begin
                m_wr = m_wr + 16'd1;
                if (a == 16'h0) m_wait = d[2:0];
                else            m_scr[(a - 16'h8) >> 2] = d;
            end else begin
                m_rd   = m_rd + 16'd1;
                e.data = v;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        model_reset();
        repeat (2) @(negedge pclk);
        preset = 1'b0;
    endtask

    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d);
        exp_t e, got;
        int   lat;
        bit   seen;
        predict(wr, a, d, e);
        sb.push_back(e);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk);
        @(negedge pclk);
        penable = 1'b1;
        lat = 0; seen = 0; got.data = '0; got.err = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge pclk); #1;
            lat++;
            if (pready) begin
                seen = 1; got.data = prdata; got.err = pslverr;
            end
        end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        e = sb.pop_front();
        chk("pready_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk($sformatf("lat@%h", a), 32'(lat), 32'(e.lat));
            chk($sformatf("prdata@%h", a), got.data, e.data);
            chk($sformatf("pslverr@%h", a), 32'(got.err), 32'(e.err));
        end
        last_rd = got.data;
        @(posedge pclk); #1;
        chk("pready_one_cycle", 32'(pready), 32'd0);
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        model_reset();
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        repeat (2) @(negedge pclk);
        preset = 1'b0;

        // Reset values
        xfer(1'b0, 16'h0, '0);
        xfer(1'b0, 16'h4, '0);

        // Scratch round trip and STATUS pre-increment value
        do_reset();
        xfer(1'b1, 16'h8, 32'hDEADBEEF);
        xfer(1'b0, 16'h8, '0);
        chk("scratch0", last_rd, 32'hDEADBEEF);
        xfer(1'b0, 16'h4, '0);
        chk("status_11", last_rd, 32'h0001_0001);

        // Wait-state sweep
        xfer(1'b1, 16'h0, 32'd4);
        xfer(1'b0, 16'h8, '0);
        for (int n = 0; n < 8; n++) begin
            xfer(1'b1, 16'h0, 32'(n));
            xfer(1'b0, 16'h8, '0);
        end

        // Error accesses leave state untouched
        xfer(1'b1, 16'h4, 32'h1234_5678);
        xfer(1'b0, 16'h2, '0);
        xfer(1'b0, 16'h20, '0);
        xfer(1'b0, 16'h4, '0);

        // Abort a WAIT_CFG=7 write to SCRATCH2 by dropping psel
        xfer(1'b1, 16'h10, 32'hA5A5_0001);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h10; pwdata = 32'hFFFF_0000;
        @(posedge pclk);
        @(negedge pclk);
        penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            chk("abort_no_pready", 32'(pready), 32'd0);
        end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 16'h10, '0);
        chk("abort_no_commit", last_rd, 32'hA5A5_0001);
        xfer(1'b0, 16'h4, '0);

        // Reset during a pending write to SCRATCH1
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'hC; pwdata = 32'hCAFE_F00D;
        @(posedge pclk);
        @(negedge pclk);
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        preset = 1'b1; psel = 1'b0; penable = 1'b0;
        model_reset();
        #1;
        chk("midrst_pready", 32'(pready), 32'd0);
        chk("midrst_prdata", prdata, 32'd0);
        chk("midrst_pslverr", 32'(pslverr), 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        xfer(1'b0, 16'hC, '0);
        chk("scratch1_clear", last_rd, 32'd0);

        // Random traffic
        for (int i = 0; i < 20; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 16'd1;
            xfer(1'($urandom_range(0, 1)), a, $urandom);
        end
        xfer(1'b0, 16'h4, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
